// File: rtl/imem_loader.sv
// Boot loader: parses a framed little-endian byte stream into 32-bit instruction-memory
// writes, verifies an XOR checksum and holds the core in reset until a good load.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StCntLo, StCntHi, StData, StCsum, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [23:0] asm_q, asm_d;  // lanes 0..2 of the word in progress; lane 3 comes from in_data
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic              xfer;

  // The write cycle doubles as the mandatory bubble between words.
  assign in_ready   = ~imem_we;
  assign xfer       = in_valid & in_ready;
  assign core_rst   = (state_q != StDone);
  assign load_done  = (state_q == StDone);
  assign load_error = (state_q == StErr);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    acc_d      = acc_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    if (xfer) begin
      if ((in_data == MAGIC) && (state_q inside {StIdle, StDone, StErr})) begin
        state_d    = StCntLo;
        acc_d      = 8'h00;
        word_idx_d = 17'd0;
        byte_idx_d = 2'd0;
      end else begin
        case (state_q)
          StCntLo: begin
            cnt_d[7:0] = in_data;
            state_d    = StCntHi;
          end
          StCntHi: begin
            cnt_d[15:8] = in_data;
            if ({1'b0, in_data, cnt_q[7:0]} > DEPTH) begin
              state_d = StErr;
            end else if ({in_data, cnt_q[7:0]} == 16'd0) begin
              state_d = StCsum;
            end else begin
              state_d = StData;
            end
          end
          StData: begin
            acc_d      = acc_q ^ in_data;
            byte_idx_d = byte_idx_q + 2'd1;
            unique case (byte_idx_q)
              2'd0: asm_d[7:0]   = in_data;
              2'd1: asm_d[15:8]  = in_data;
              2'd2: asm_d[23:16] = in_data;
              2'd3: begin
                we_d       = 1'b1;
                addr_d     = word_idx_q[ADDR_W-1:0];
                wdata_d    = {in_data, asm_q};
                word_idx_d = word_idx_q + 17'd1;
                if (word_idx_q + 17'd1 == {1'b0, cnt_q}) begin
                  state_d = StCsum;
                end
              end
            endcase
          end
          StCsum:  state_d = (in_data == acc_q) ? StDone : StErr;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      word_idx_q <= 17'd0;
      byte_idx_q <= 2'd0;
      acc_q      <= 8'h00;
      asm_q      <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      acc_q      <= acc_d;
      asm_q      <= asm_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random frames against a frame-level reference model.
module tb_imem_loader;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, imem_we, core_rst, load_done, load_error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [39:0] wq[$];      // observed writes {addr, data}
  logic [39:0] exp_wq[$];  // model writes
  logic [7:0]  fb[$];      // frame bytes to send
  logic [31:0] mem_seen[DEPTH];
  logic [31:0] exp_mem[DEPTH];
  bit          exp_done, exp_err;
  logic        prev_we = 1'b0;

  imem_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Write monitor: records every write and checks the ready/strobe relationship.
  always @(negedge clk) begin
    if (rst) begin
      prev_we <= 1'b0;
    end else begin
      n_cmp++;
      if (in_ready !== ~imem_we) begin
        n_bad++;
        $display("FAIL ready_vs_we in_ready=%b required=%b", in_ready, ~imem_we);
      end
      if (imem_we === 1'b1) begin
        n_cmp++;
        if (prev_we) begin
          n_bad++;
          $display("FAIL we_pulse imem_we high=2 cycles required=1 cycle");
        end
        wq.push_back({imem_addr, imem_wdata});
        mem_seen[imem_addr] <= imem_wdata;
      end
      prev_we <= imem_we;
    end
  end

  // Reference model: interprets the frame in fb by the framing rules.
  function automatic void model_frame();
    int s = 0;
    int cnt;
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    while (s < fb.size() && fb[s] != 8'hA5) s++;
    cnt = int'(fb[s+1]) + 256 * int'(fb[s+2]);
    exp_wq.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (cnt > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      w = {fb[s+6+4*i], fb[s+5+4*i], fb[s+4+4*i], fb[s+3+4*i]};
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      exp_wq.push_back({i[7:0], w});
      exp_mem[i] = w;
    end
    exp_done = (fb[s+3+4*cnt] == x);
    exp_err  = !exp_done;
  endfunction

  function automatic void build_frame(input int cnt, input bit bad);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(cnt[7:0]);
    fb.push_back(cnt[15:8]);
    for (int i = 0; i < cnt * 4; i++) begin
      b = 8'($urandom);
      fb.push_back(b);
      cs ^= b;
    end
    fb.push_back(bad ? cs ^ 8'($urandom_range(1, 255)) : cs);
  endfunction

  // Presents one byte and returns 1 time unit after the edge that transfers it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    @(negedge clk);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout in_ready=%b required=1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int start, input bit gaps);
    for (int i = start; i < fb.size(); i++) send_byte(fb[i], gaps);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 7;
    if (core_rst !== 1'b1)   begin n_bad++; $display("FAIL rst_core_rst got=%b exp=1", core_rst); end
    if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    if (imem_we !== 1'b0)    begin n_bad++; $display("FAIL rst_imem_we got=%b exp=0", imem_we); end
    if (load_done !== 1'b0)  begin n_bad++; $display("FAIL rst_done got=%b exp=0", load_done); end
    if (load_error !== 1'b0) begin n_bad++; $display("FAIL rst_error got=%b exp=0", load_error); end
    if (imem_addr !== '0)    begin n_bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    if (imem_wdata !== '0)   begin n_bad++; $display("FAIL rst_wdata got=%h exp=0", imem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_good_two_word();
    logic [7:0] hdr[$] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                           8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] x = 8'h00;
    for (int i = 3; i < hdr.size(); i++) x ^= hdr[i];
    fb = hdr;
    fb.push_back(x);  // checksum is the XOR of the eight data bytes
    wq.delete();
    send_frame(0, 1'b0);
    model_frame();
    n_cmp += 5;
    if (wq.size() != 2) begin
      n_bad++; $display("FAIL two_word_count got=%0d exp=2", wq.size());
    end else begin
      if (wq[0] !== {8'h00, 32'h12345678}) begin n_bad++; $display("FAIL two_word_w0 got=%h exp=0012345678", wq[0]); end
      if (wq[1] !== {8'h01, 32'hDEADBEEF}) begin n_bad++; $display("FAIL two_word_w1 got=%h exp=01deadbeef", wq[1]); end
    end
    if (load_done !== 1'b1) begin n_bad++; $display("FAIL two_word_done got=%b exp=1", load_done); end
    if (core_rst !== 1'b0)  begin n_bad++; $display("FAIL two_word_core_rst got=%b exp=0", core_rst); end
  endtask

  task automatic test_bad_checksum();
    fb = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
    send_frame(0, 1'b0);
    model_frame();
    n_cmp += 3;
    if (load_error !== exp_err) begin n_bad++; $display("FAIL bad_cs_error got=%b exp=%b", load_error, exp_err); end
    if (core_rst !== 1'b1)      begin n_bad++; $display("FAIL bad_cs_core_rst got=%b exp=1", core_rst); end
    if (load_done !== 1'b0)     begin n_bad++; $display("FAIL bad_cs_done got=%b exp=0", load_done); end
    build_frame(5, 1'b0);
    wq.delete();
    send_frame(0, 1'b1);
    model_frame();
    n_cmp += 3;
    if (load_done !== 1'b1)  begin n_bad++; $display("FAIL recover_done got=%b exp=1", load_done); end
    if (load_error !== 1'b0) begin n_bad++; $display("FAIL recover_error got=%b exp=0", load_error); end
    if (wq != exp_wq)        begin n_bad++; $display("FAIL recover_writes got=%0d words exp=%0d", wq.size(), exp_wq.size()); end
  endtask

  task automatic test_oversize();
    fb = '{8'hA5, 8'h01, 8'h01};
    wq.delete();
    send_frame(0, 1'b0);
    model_frame();
    n_cmp += 2;
    if (load_error !== exp_err) begin n_bad++; $display("FAIL oversize_error got=%b exp=%b", load_error, exp_err); end
    if (core_rst !== 1'b1)      begin n_bad++; $display("FAIL oversize_core_rst got=%b exp=1", core_rst); end
    for (int i = 0; i < 8; i++) send_byte(8'(i * 17 + 3), 1'b0);  // never 8'hA5
    n_cmp += 2;
    if (wq.size() != 0)      begin n_bad++; $display("FAIL oversize_writes got=%0d exp=0", wq.size()); end
    if (load_error !== 1'b1) begin n_bad++; $display("FAIL oversize_hold got=%b exp=1", load_error); end
  endtask

  task automatic test_full_depth();
    build_frame(DEPTH, 1'b0);
    wq.delete();
    send_frame(0, 1'b0);
    model_frame();
    n_cmp += 3;
    if (wq != exp_wq) begin n_bad++; $display("FAIL full_writes got=%0d words exp=%0d", wq.size(), exp_wq.size()); end
    if (wq.size() == 0 || wq[wq.size()-1][39:32] !== 8'hFF) begin
      n_bad++; $display("FAIL full_last_addr got=%0d words exp=last addr ff", wq.size());
    end
    if (load_done !== exp_done) begin n_bad++; $display("FAIL full_done got=%b exp=%b", load_done, exp_done); end
  endtask

  task automatic test_zero_and_magic_csum();
    build_frame(0, 1'b0);
    wq.delete();
    send_frame(0, 1'b1);
    model_frame();
    n_cmp += 2;
    if (wq.size() != 0)         begin n_bad++; $display("FAIL zero_writes got=%0d exp=0", wq.size()); end
    if (load_done !== exp_done) begin n_bad++; $display("FAIL zero_done got=%b exp=%b", load_done, exp_done); end
    // Magic value as a data byte and as the checksum byte.
    fb = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5};
    wq.delete();
    send_frame(0, 1'b0);
    model_frame();
    n_cmp += 2;
    if (wq != exp_wq)           begin n_bad++; $display("FAIL magic_csum_writes got=%0d words exp=%0d", wq.size(), exp_wq.size()); end
    if (load_done !== exp_done) begin n_bad++; $display("FAIL magic_csum_done got=%b exp=%b", load_done, exp_done); end
  endtask

  task automatic test_noise_backpressure();
    logic [7:0] noise[$] = '{8'h00, 8'hFF, 8'h5A};
    for (int it = 0; it < 6; it++) begin
      build_frame(int'($urandom_range(1, 12)), bit'($urandom_range(0, 1)));
      for (int k = 2; k >= 0; k--) fb.push_front(noise[k]);
      wq.delete();
      send_frame(0, bit'(it % 2));
      model_frame();
      n_cmp += 3;
      if (wq != exp_wq) begin n_bad++; $display("FAIL noise_writes_%0d got=%0d words exp=%0d", it, wq.size(), exp_wq.size()); end
      if (load_done !== exp_done) begin n_bad++; $display("FAIL noise_done_%0d got=%b exp=%b", it, load_done, exp_done); end
      if (load_error !== exp_err) begin n_bad++; $display("FAIL noise_error_%0d got=%b exp=%b", it, load_error, exp_err); end
    end
  endtask

  task automatic test_reload();
    int diffs = 0;
    build_frame(6, 1'b0);
    send_frame(0, 1'b0);
    model_frame();
    build_frame(3, 1'b0);
    send_byte(fb[0], 1'b0);
    n_cmp += 3;
    if (core_rst !== 1'b1)   begin n_bad++; $display("FAIL reload_core_rst got=%b exp=1", core_rst); end
    if (load_done !== 1'b0)  begin n_bad++; $display("FAIL reload_done got=%b exp=0", load_done); end
    if (load_error !== 1'b0) begin n_bad++; $display("FAIL reload_error got=%b exp=0", load_error); end
    send_frame(1, 1'b1);
    model_frame();
    @(negedge clk);
    foreach (exp_mem[i]) if (mem_seen[i] !== exp_mem[i]) diffs++;
    n_cmp += 2;
    if (load_done !== exp_done) begin n_bad++; $display("FAIL reload_final_done got=%b exp=%b", load_done, exp_done); end
    if (diffs != 0)             begin n_bad++; $display("FAIL reload_mem got=%0d differing words exp=0", diffs); end
  endtask

  task automatic test_async_reset();
    int diffs = 0;
    build_frame(4, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(fb[i], 1'b0);
    exp_mem[0] = {fb[6], fb[5], fb[4], fb[3]};
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp += 5;
    if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL async_in_ready got=%b exp=1", in_ready); end
    if (imem_we !== 1'b0)   begin n_bad++; $display("FAIL async_imem_we got=%b exp=0", imem_we); end
    if (core_rst !== 1'b1)  begin n_bad++; $display("FAIL async_core_rst got=%b exp=1", core_rst); end
    if (imem_addr !== '0)   begin n_bad++; $display("FAIL async_addr got=%h exp=0", imem_addr); end
    if (imem_wdata !== '0)  begin n_bad++; $display("FAIL async_wdata got=%h exp=0", imem_wdata); end
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
    for (int i = 8; i < fb.size(); i++) send_byte((fb[i] == 8'hA5) ? 8'h11 : fb[i], 1'b0);
    repeat (2) @(negedge clk);
    foreach (exp_mem[i]) if (mem_seen[i] !== exp_mem[i]) diffs++;
    n_cmp += 4;
    if (wq.size() != 0)     begin n_bad++; $display("FAIL async_idle_writes got=%0d exp=0", wq.size()); end
    if (core_rst !== 1'b1)  begin n_bad++; $display("FAIL async_idle_core_rst got=%b exp=1", core_rst); end
    if (load_done !== 1'b0) begin n_bad++; $display("FAIL async_idle_done got=%b exp=0", load_done); end
    if (diffs != 0)         begin n_bad++; $display("FAIL async_mem_kept got=%0d differing words exp=0", diffs); end
  endtask

  initial begin
    foreach (mem_seen[i]) begin
      mem_seen[i] = 32'd0;
      exp_mem[i]  = 32'd0;
    end
    test_reset();
    test_good_two_word();
    test_bad_checksum();
    test_oversize();
    test_full_depth();
    test_zero_and_magic_csum();
    test_noise_backpressure();
    test_reload();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
